rr_hold_arbiter16: RTL and testbench
====================================

Name: rr_hold_arbiter16

Overview:
Sequential round-robin arbiter that shares one resource among 16 requesters. It uses the 4-input priority-encode cell idea, adding a rotating priority pointer, grant hold/ownership and a hold timeout. It sits above a level of 4-input request cells, or directly on 16 raw requesters. It exports an OR-ed request upward so it can be chained into a larger tree.

Parameters:
NUM_REQ, 16, number of requesters; fixed at 16, other values unsupported.
MAX_HOLD, 15, maximum consecutive cycles one requester may own the grant; legal range 1..255.
CNT_W, 8, hold counter width; must hold MAX_HOLD.

Ports:
Clock_IN  input  1  single clock, rising edge.
Reset_N_IN  input  1  synchronous, active-low reset.
Enable_IN  input  1  grant permission from upstream (root grant); 0 forces all grants off.
Request_IN  input  16  per-requester request, level-sensitive.
Request_OUT  output  1  combinational OR of Request_IN, independent of Enable_IN and state.
Grant_OUT  output  16  registered one-hot grant, all-zero when no owner.
Grant_Valid_OUT  output  1  registered; 1 iff Grant_OUT is non-zero.
Grant_Index_OUT  output  4  registered index of owner; 0 when Grant_Valid_OUT=0.
Timeout_OUT  output  1  registered one-cycle pulse on forced release.

Behaviour:
- Interface: one clock, Clock_IN. Reset_N_IN is synchronous and active-low.
- Reset: with Reset_N_IN=0 at a rising edge:
  - Grant_OUT=0, Grant_Valid_OUT=0, Grant_Index_OUT=0, Timeout_OUT=0.
  - State=IDLE, pointer=0, hold counter=0.
  - Reset applies mid-ownership too; no release bookkeeping is done and the pointer returns to 0.
- Pick function (combinational):
  - Candidates = Request_IN & ~mask.
  - Winner = first set candidate scanning pointer, pointer+1, ..., 15, 0, ... (mod 16).
  - "none" if no candidate.
- States: IDLE, OWN.
- IDLE:
  - If Enable_IN=1 and pick (mask=0) finds a winner: at the next edge, Grant_OUT=onehot(winner), Grant_Index_OUT=winner, counter=1, state→OWN.
  - Latency: request sampled at edge k, grant visible after edge k (i.e. during cycle k+1).
  - Otherwise stay IDLE with outputs zero.
- OWN, owner o, with priority order: Enable_IN=0 > owner drop > timeout > hold.
  - Enable_IN=0: grants cleared at the next edge, pointer=(o+1) mod 16, state→IDLE, Timeout_OUT=0.
  - Owner drop (Request_IN[o]=0): release. Re-pick with mask=onehot(o) and pointer=(o+1) mod 16, updating the pointer the same edge.
    - Winner w exists: Grant_OUT=onehot(w) directly (zero-bubble handover), counter=1, stay OWN.
    - No winner: state→IDLE, outputs zero.
  - Timeout (Request_IN[o]=1 and counter==MAX_HOLD): forced release, identical to drop but Timeout_OUT=1 for exactly that next cycle.
    - If o is the only requester: one idle cycle, then o is re-granted (from IDLE) on the following edge.
  - Otherwise: hold the grant, counter+1 (saturates at MAX_HOLD).
- Guarantees:
  - Grant_OUT is never multi-hot.
  - A grant never goes to a requester whose Request_IN was 0 at the deciding edge.
  - Consecutive grant cycles per owner ≤ MAX_HOLD.
- Simultaneous events:
  - New requests arriving during OWN do not pre-empt the owner.
  - Owner drop and Enable_IN=0 in the same cycle → Enable rule applies (all grants off).
- Pointer wraps 15→0. Counter arithmetic is unsigned CNT_W bits with no wrap.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ, IDX_W=4.
  - State enum {IDLE, OWN}.
  - Function onehot16(idx).
- Sub-module rr_pick16: combinational rotating priority encoder built from four 4-input priority cells (double-width masked-request technique). Inputs: req[15:0], ptr[3:0]. Outputs: valid, idx[3:0].
- FSM, pointer, counter and output registers stay in rr_hold_arbiter16.

Test Plan:
1. Reset: hold Reset_N_IN=0 for 2 edges with Request_IN=16'hFFFF, Enable_IN=1 → all outputs 0. Release reset → after 1 edge Grant_OUT=16'h0001, Grant_Index_OUT=0.
2. Handover: Request_IN=16'h0011, owner 0 drops bit 0 after 3 cycles → the next edge gives Grant_OUT=16'h0010 with no zero cycle, and pointer=1.
3. Timeout, MAX_HOLD=4: only requester 5 held high → Grant_OUT=16'h0020 for exactly 4 cycles, Timeout_OUT=1 one cycle with Grant_OUT=0, then re-granted to 5.
4. Fairness: Request_IN=16'hFFFF constant, each owner drops after 1 cycle → grant indices 0,1,2,...,15,0 in order, no repeats before wrap.
5. Enable kill: owner 7 active, Enable_IN=0 for 1 cycle → Grant_OUT=0 next cycle. Re-enable with Request_IN=16'h0080 only → grant 7 again, since pointer=8 wraps around to 7.
6. Mid-operation reset: owner 9 with counter=3, Reset_N_IN=0 one edge → all outputs 0. After release with Request_IN=16'h0202 → grant 1, because the pointer reset to 0.

Source files
------------

// File: rtl/rr_hold_arbiter16_pkg.sv
// Shared types and helpers for the 16-way hold/round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic {IDLE, OWN} state_e;

  function automatic logic [NUM_REQ-1:0] onehot16(input logic [IDX_W-1:0] idx);
    onehot16 = NUM_REQ'(1) << idx;
  endfunction

  // 4-input priority cell: lowest set bit wins.
  function automatic logic [1:0] pri4(input logic [3:0] r);
    if (r[0])      pri4 = 2'd0;
    else if (r[1]) pri4 = 2'd1;
    else if (r[2]) pri4 = 2'd2;
    else           pri4 = 2'd3;
  endfunction
endpackage

// File: rtl/rr_hold_arbiter16_if.sv
// Request/pointer in, winner out: the link between the arbiter FSM and its picker.
interface rr_hold_arbiter16_if;
  logic [15:0] req;
  logic [3:0]  ptr;
  logic        vld;
  logic [3:0]  idx;

  modport master (output req, ptr, input  vld, idx);
  modport slave  (input  req, ptr, output vld, idx);
endinterface

// File: rtl/rr_hold_arbiter16_pick.sv
// Rotating priority encoder: rotate so ptr lands at bit 0, encode with four
// 4-input cells plus a group-level cell, then rotate the index back.
module rr_pick16
  import arb_pkg::*;
(
  rr_hold_arbiter16_if.slave p
);
  logic [15:0]      rot;
  logic [3:0]       gv;
  logic [3:0][1:0]  gi;
  logic [1:0]       gsel;

  assign rot = 16'({p.req, p.req} >> p.ptr);

  for (genvar g = 0; g < 4; g++) begin : g_cell
    assign gv[g] = |rot[4*g +: 4];
    assign gi[g] = pri4(rot[4*g +: 4]);
  end

  assign gsel  = pri4(gv);
  assign p.vld = |gv;
  assign p.idx = {gsel, gi[gsel]} + p.ptr;
endmodule

// File: rtl/rr_hold_arbiter16.sv
// Round-robin arbiter with grant ownership, hold timeout and zero-bubble handover.
module rr_hold_arbiter16 #(
  parameter int NUM_REQ  = 16,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic               Clock_IN,
  input  logic               Reset_N_IN,
  input  logic               Enable_IN,
  input  logic [NUM_REQ-1:0] Request_IN,
  output logic               Request_OUT,
  output logic [NUM_REQ-1:0] Grant_OUT,
  output logic               Grant_Valid_OUT,
  output logic [3:0]         Grant_Index_OUT,
  output logic               Timeout_OUT
);
  import arb_pkg::*;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_HOLD);

  state_e             state_q;
  logic [3:0]         ptr_q, gidx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               gvld_q, to_q;
  logic               release_w;

  rr_hold_arbiter16_if pk ();
  rr_pick16 u_pick (.p(pk));

  // While owning, the re-pick excludes the owner and starts just past it.
  always_comb begin
    pk.req = Request_IN;
    pk.ptr = ptr_q;
    if (state_q == OWN) begin
      pk.req = Request_IN & ~onehot16(gidx_q);
      pk.ptr = gidx_q + 4'd1;
    end
  end

  assign release_w = !Request_IN[gidx_q] || (cnt_q == MAXC);

  always_ff @(posedge Clock_IN) begin
    if (!Reset_N_IN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      gvld_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Enable_IN && pk.vld) begin
            state_q <= OWN;
            grant_q <= onehot16(pk.idx);
            gidx_q  <= pk.idx;
            gvld_q  <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        end
        OWN: begin
          if (!Enable_IN || release_w) begin
            ptr_q <= gidx_q + 4'd1;
            // Owner still requesting means the hold limit forced it out.
            to_q  <= Enable_IN && Request_IN[gidx_q];
            if (Enable_IN && pk.vld) begin
              grant_q <= onehot16(pk.idx);
              gidx_q  <= pk.idx;
              cnt_q   <= CNT_W'(1);
            end else begin
              state_q <= IDLE;
              grant_q <= '0;
              gidx_q  <= '0;
              gvld_q  <= 1'b0;
              cnt_q   <= '0;
            end
          end else if (cnt_q != MAXC) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Request_OUT     = |Request_IN;
  assign Grant_OUT       = grant_q;
  assign Grant_Valid_OUT = gvld_q;
  assign Grant_Index_OUT = gidx_q;
  assign Timeout_OUT     = to_q;
endmodule

// File: tb/tb_rr_hold_arbiter16.sv
// Directed bench for rr_hold_arbiter16 (MAX_HOLD=4) with hand-computed expectations.
module tb_rr_hold_arbiter16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        req_or;
  logic [15:0] grant;
  logic        to;
  int          errors = 0;
  int          checks = 0;

  rr_hold_arbiter16_if tb_if ();

  rr_hold_arbiter16 #(.NUM_REQ(16), .MAX_HOLD(4), .CNT_W(8)) dut (
    .Clock_IN        (clk),
    .Reset_N_IN      (rst_n),
    .Enable_IN       (en),
    .Request_IN      (tb_if.req),
    .Request_OUT     (req_or),
    .Grant_OUT       (grant),
    .Grant_Valid_OUT (tb_if.vld),
    .Grant_Index_OUT (tb_if.idx),
    .Timeout_OUT     (to)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check all registered outputs against an expected one-hot grant and timeout.
  task automatic chk_out(input string tag, input logic [15:0] eg, input logic eto);
    logic [3:0] ei;
    ei = 4'd0;
    for (int i = 0; i < 16; i++) if (eg[i]) ei = 4'(i);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(tb_if.vld), 32'(eg != 16'h0));
    chk({tag, ".index"}, 32'(tb_if.idx), 32'(ei));
    chk({tag, ".timeout"}, 32'(to), 32'(eto));
  endtask

  initial begin
    tb_if.ptr = 4'd0;
    // Reset with everything requesting
    rst_n = 1'b0; en = 1'b1; tb_if.req = 16'hFFFF;
    tick(); tick();
    chk_out("reset", 16'h0000, 1'b0);
    chk("reqor_all", 32'(req_or), 32'd1);
    rst_n = 1'b1;
    tick();
    chk_out("first_grant", 16'h0001, 1'b0);

    // Handover 0 -> 4 with no bubble
    tb_if.req = 16'h0011;
    tick(); chk_out("hold0_c2", 16'h0001, 1'b0);
    tick(); chk_out("hold0_c3", 16'h0001, 1'b0);
    tb_if.req = 16'h0010;
    tick(); chk_out("handover4", 16'h0010, 1'b0);

    // Timeout on lone requester 5
    tb_if.req = 16'h0020;
    tick(); chk_out("own5_c1", 16'h0020, 1'b0);
    tick(); chk_out("own5_c2", 16'h0020, 1'b0);
    tick(); chk_out("own5_c3", 16'h0020, 1'b0);
    tick(); chk_out("own5_c4", 16'h0020, 1'b0);
    tick(); chk_out("timeout5", 16'h0000, 1'b1);
    tick(); chk_out("regrant5", 16'h0020, 1'b0);
    tick(); chk_out("regrant5_c2", 16'h0020, 1'b0);

    // Fairness sweep from a fresh pointer
    rst_n = 1'b0; tb_if.req = 16'hFFFF;
    tick();
    rst_n = 1'b1;
    tick(); chk_out("fair_start", 16'h0001, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      tb_if.req = 16'hFFFF & ~(16'h0001 << ((k - 1) % 16));
      tick();
      chk_out($sformatf("fair_%0d", k), 16'h0001 << (k % 16), 1'b0);
    end

    // Enable kill, pointer wraps back to 7
    tb_if.req = 16'h0080;
    tick(); chk_out("own7", 16'h0080, 1'b0);
    en = 1'b0;
    tick(); chk_out("kill", 16'h0000, 1'b0);
    chk("reqor_noen", 32'(req_or), 32'd1);
    en = 1'b1;
    tick(); chk_out("regrant7", 16'h0080, 1'b0);

    // Drop and disable together: enable rule wins, no timeout
    en = 1'b0; tb_if.req = 16'h0100;
    tick(); chk_out("drop_kill", 16'h0000, 1'b0);
    en = 1'b1; tb_if.req = 16'h0000;
    #1 chk("reqor_none", 32'(req_or), 32'd0);
    tick(); chk_out("idle_none", 16'h0000, 1'b0);

    // Mid-ownership reset returns pointer to 0
    tb_if.req = 16'h0200;
    tick(); chk_out("own9_c1", 16'h0200, 1'b0);
    tick(); tick(); chk_out("own9_c3", 16'h0200, 1'b0);
    rst_n = 1'b0;
    tick(); chk_out("mid_reset", 16'h0000, 1'b0);
    rst_n = 1'b1; tb_if.req = 16'h0202;
    tick(); chk_out("post_reset", 16'h0002, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
